// File: rtl/vector_issue_stage_if.sv
// Handshake and issue bus between the decode side, the issue stage and the execute stage.
// The stage side uses the slave modport. The upstream/environment side uses the master modport.
interface vector_issue_stage_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int ELEN_FIELD = 3,
  parameter int FIFO_DEPTH = 4
);
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_src1;
  logic [ADDR_WIDTH-1:0] in_src2;
  logic [ADDR_WIDTH-1:0] in_dst;
  logic [ELEN_FIELD-1:0] in_elen;
  logic [2:0]            in_opcode;

  logic                  instr_valid;
  logic [ADDR_WIDTH-1:0] src1;
  logic [ADDR_WIDTH-1:0] src2;
  logic [ADDR_WIDTH-1:0] dst;
  logic [ELEN_FIELD-1:0] elen;
  logic [2:0]            opcode;
  logic                  wb_valid;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic                  busy;
  logic                  err_illegal;
  logic [OCC_W-1:0]      occupancy;

  modport master (
    output in_valid, in_src1, in_src2, in_dst, in_elen, in_opcode,
    input  in_ready, instr_valid, src1, src2, dst, elen, opcode,
           wb_valid, wb_addr, busy, err_illegal, occupancy
  );

  modport slave (
    input  in_valid, in_src1, in_src2, in_dst, in_elen, in_opcode,
    output in_ready, instr_valid, src1, src2, dst, elen, opcode,
           wb_valid, wb_addr, busy, err_illegal, occupancy
  );
endinterface

// File: rtl/vector_issue_stage.sv
// In-order vector issue stage: a small instruction FIFO feeds a single in-flight slot
// whose operands are held stable until the execute stage returns its writeback tag.
module vector_issue_stage #(
  parameter int ADDR_WIDTH   = 5,
  parameter int ELEN_FIELD   = 3,
  parameter int MAX_ELEN     = 5,
  parameter int FIFO_DEPTH   = 4,
  parameter int EXEC_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  vector_issue_stage_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = $clog2(EXEC_LATENCY);
  localparam logic [ELEN_FIELD-1:0] MAX_ELEN_C = ELEN_FIELD'(MAX_ELEN);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] src1;
    logic [ADDR_WIDTH-1:0] src2;
    logic [ADDR_WIDTH-1:0] dst;
    logic [ELEN_FIELD-1:0] elen;
    logic [2:0]            opcode;
  } instr_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  instr_t           hold_q, hold_d;
  logic             err_q, err_d;
  instr_t           mem_q [FIFO_DEPTH];

  instr_t in_instr;
  logic   full, empty, accept, legal, push, pop;

  assign in_instr = '{src1: bus.in_src1, src2: bus.in_src2, dst: bus.in_dst,
                      elen: bus.in_elen, opcode: bus.in_opcode};

  // Ready depends on registered occupancy only; a pop in the same cycle does not free a slot early.
  assign full   = (count_q == OCC_W'(FIFO_DEPTH));
  assign empty  = (count_q == '0);
  assign accept = bus.in_valid && !full;
  assign legal  = (bus.in_elen <= MAX_ELEN_C);
  assign push   = accept && legal;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(EXEC_LATENCY - 1);
        state_d = S_BUSY;
      end
      S_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    hold_d   = pop  ? mem_q[rd_ptr_q] : hold_q;
    err_d    = accept && !legal;
    unique case ({push, pop})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
      err_q    <= err_d;
    end
  end

  // NOTE: queue storage is not reset; an entry is only read after a push has written it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_instr;
  end

  assign bus.in_ready    = !full;
  assign bus.instr_valid = (state_q == S_ISSUE);
  assign bus.wb_valid    = (state_q == S_DONE);
  assign bus.wb_addr     = hold_q.dst;
  assign bus.src1        = hold_q.src1;
  assign bus.src2        = hold_q.src2;
  assign bus.dst         = hold_q.dst;
  assign bus.elen        = hold_q.elen;
  assign bus.opcode      = hold_q.opcode;
  assign bus.busy        = (state_q != S_IDLE) || !empty;
  assign bus.err_illegal = err_q;
  assign bus.occupancy   = count_q;
endmodule
